// File: rtl/fp_accum.sv
`default_nettype none
// ============================================================================
// fp_accum : FP32 running-sum accumulator for multiplier products. Each term
//            takes three cycles: align, add, normalise (truncating).
// Revision : 1.0
// ============================================================================
module fp_accum #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             sum_valid,
   output logic [31:0]      sum,
   output logic [31:0]      acc,
   output logic [CNT_W-1:0] term_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_ADD   = 2'd2,
      ST_NORM  = 2'd3
   } state_t;

   state_t           state_q,     state_d;
   logic [31:0]      term_q,      term_d;
   logic             last_q,      last_d;
   logic [31:0]      acc_q,       acc_d;
   logic [31:0]      sum_q,       sum_d;
   logic             sum_valid_q, sum_valid_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             sign_a_q,    sign_a_d;
   logic             sign_b_q,    sign_b_d;
   logic [7:0]       exp_a_q,     exp_a_d;
   logic [26:0]      man_a_q,     man_a_d;
   logic [26:0]      man_b_q,     man_b_d;
   logic [27:0]      add_q,       add_d;

   logic [7:0]       exp_x, exp_y;
   logic [23:0]      man_x, man_y;
   logic             al_sign_a, al_sign_b;
   logic [7:0]       al_exp_a, al_exp_b, al_shift;
   logic [23:0]      al_man_a, al_man_b;
   logic [26:0]      al_man_b_sh;

   logic [4:0]       lzc;
   logic [26:0]      norm_man;
   logic signed [9:0] norm_exp;
   logic [31:0]      result;
   logic             unused_bits;

   // Align: operand A (larger magnitude) keeps its exponent, B is shifted down.
   always_comb begin : p_align
      exp_x = acc_q[30:23];
      exp_y = term_q[30:23];
      man_x = (exp_x != 8'd0) ? {1'b1, acc_q[22:0]}  : 24'd0;
      man_y = (exp_y != 8'd0) ? {1'b1, term_q[22:0]} : 24'd0;
      if ({exp_x, man_x} >= {exp_y, man_y}) begin
         al_sign_a = acc_q[31];
         al_sign_b = term_q[31];
         al_exp_a  = exp_x;
         al_exp_b  = exp_y;
         al_man_a  = man_x;
         al_man_b  = man_y;
      end else begin
         al_sign_a = term_q[31];
         al_sign_b = acc_q[31];
         al_exp_a  = exp_y;
         al_exp_b  = exp_x;
         al_man_a  = man_y;
         al_man_b  = man_x;
      end
      al_shift    = al_exp_a - al_exp_b;
      al_man_b_sh = (al_shift >= 8'd27) ? 27'd0 : ({al_man_b, 3'b000} >> al_shift);
   end

   always_comb begin : p_norm
      lzc = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (add_q[i]) lzc = 5'(26 - i);
      end
      if (add_q[27]) begin
         norm_man = add_q[27:1];
         norm_exp = $signed({2'b00, exp_a_q}) + 10'sd1;
      end else begin
         norm_man = add_q[26:0] << lzc;
         norm_exp = $signed({2'b00, exp_a_q}) - $signed({5'd0, lzc});
      end
      if (add_q == 28'd0) begin
         result = 32'd0;
      end else if (norm_exp >= 10'sd255) begin
         result = {sign_a_q, 8'hFF, 23'd0};
      end else if (norm_exp <= 10'sd0) begin
         result = 32'd0;
      end else begin
         result = {sign_a_q, norm_exp[7:0], norm_man[25:3]};
      end
   end

   assign unused_bits = ^{norm_man[26], norm_man[2:0]};

   always_comb begin : p_next
      state_d     = state_q;
      term_d      = term_q;
      last_d      = last_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;
      cnt_d       = cnt_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      exp_a_d     = exp_a_q;
      man_a_d     = man_a_q;
      man_b_d     = man_b_q;
      add_d       = add_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_ALIGN;
               term_d  = in_data;
               last_d  = in_last;
               // Clearing with a term starts a fresh group: the add sees A = 0.
               if (clear) begin
                  acc_d = 32'd0;
                  cnt_d = CNT_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (clear) begin
               acc_d = 32'd0;
               cnt_d = '0;
            end
         end
         ST_ALIGN: begin
            state_d  = ST_ADD;
            sign_a_d = al_sign_a;
            sign_b_d = al_sign_b;
            exp_a_d  = al_exp_a;
            man_a_d  = {al_man_a, 3'b000};
            man_b_d  = al_man_b_sh;
         end
         ST_ADD: begin
            state_d = ST_NORM;
            if (sign_a_q == sign_b_q) begin
               add_d = {1'b0, man_a_q} + {1'b0, man_b_q};
            end else begin
               add_d = {1'b0, man_a_q} - {1'b0, man_b_q};
            end
         end
         ST_NORM: begin
            state_d = ST_IDLE;
            if (last_q) begin
               sum_d       = result;
               sum_valid_d = 1'b1;
               acc_d       = 32'd0;
               cnt_d       = '0;
            end else begin
               acc_d = result;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         term_q      <= 32'd0;
         last_q      <= 1'b0;
         acc_q       <= 32'd0;
         sum_q       <= 32'd0;
         sum_valid_q <= 1'b0;
         cnt_q       <= '0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         exp_a_q     <= 8'd0;
         man_a_q     <= 27'd0;
         man_b_q     <= 27'd0;
         add_q       <= 28'd0;
      end else begin
         state_q     <= state_d;
         term_q      <= term_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
         cnt_q       <= cnt_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         exp_a_q     <= exp_a_d;
         man_a_q     <= man_a_d;
         man_b_q     <= man_b_d;
         add_q       <= add_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign sum_valid = sum_valid_q;
   assign sum       = sum_q;
   assign acc       = acc_q;
   assign term_cnt  = cnt_q;

endmodule
`default_nettype wire
